// File: rtl/hazard_stall_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// hazard_stall_ctrl_pkg
// Shared types and constants for the LEGv8 interlock controller:
//   state_e          - controller states (RUN, BR_WAIT)
//   XZR              - the zero register, which never creates a dependency
//   sb_entry_t       - one scoreboard slot {v, rd}
//   SB_DEPTH_DEFAULT - default number of tracked stages past ID
//   src_hit()        - one source-operand vs. one scoreboard slot compare
// ----------------------------------------------------------------------------
package hazard_stall_ctrl_pkg;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_BR_WAIT = 1'b1
  } state_e;

  localparam logic [4:0] XZR = 5'd31;

  localparam int SB_DEPTH_DEFAULT = 3;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
  } sb_entry_t;

  // A read of XZR is always satisfied, so it never matches a producer.
  function automatic logic src_hit(logic reads, logic [4:0] src, sb_entry_t e);
    return reads && (src != XZR) && e.v && (e.rd == src);
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// ----------------------------------------------------------------------------
// hazard_stall_ctrl_if
// Decode-side bundle between the ID stage and the interlock controller.
//   master : decode stage / branch unit (drives *_i, observes *_o)
//   slave  : hazard_stall_ctrl
// Decode inputs : id_valid_i, id_ra_i, id_rb_i, id_use_a_i, id_use_b_i,
//                 id_regwrite_i, id_rd_i, id_branch_i, br_resolved_i
// Control outs  : pc_hold_o, ifid_hold_o, ifid_flush_o, idex_bubble_o, br_err_o
// HAZARD_PERF_EN: adds stall_cnt_o / brwait_cnt_o (32-bit performance counts).
// ----------------------------------------------------------------------------
interface hazard_stall_ctrl_if;

  logic       id_valid_i;
  logic [4:0] id_ra_i;
  logic [4:0] id_rb_i;
  logic       id_use_a_i;
  logic       id_use_b_i;
  logic       id_regwrite_i;
  logic [4:0] id_rd_i;
  logic       id_branch_i;
  logic       br_resolved_i;

  logic       pc_hold_o;
  logic       ifid_hold_o;
  logic       ifid_flush_o;
  logic       idex_bubble_o;
  logic       br_err_o;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_o;
  logic [31:0] brwait_cnt_o;

  modport master (
    output id_valid_i, id_ra_i, id_rb_i, id_use_a_i, id_use_b_i,
           id_regwrite_i, id_rd_i, id_branch_i, br_resolved_i,
    input  pc_hold_o, ifid_hold_o, ifid_flush_o, idex_bubble_o, br_err_o,
           stall_cnt_o, brwait_cnt_o
  );

  modport slave (
    input  id_valid_i, id_ra_i, id_rb_i, id_use_a_i, id_use_b_i,
           id_regwrite_i, id_rd_i, id_branch_i, br_resolved_i,
    output pc_hold_o, ifid_hold_o, ifid_flush_o, idex_bubble_o, br_err_o,
           stall_cnt_o, brwait_cnt_o
  );
`else
  modport master (
    output id_valid_i, id_ra_i, id_rb_i, id_use_a_i, id_use_b_i,
           id_regwrite_i, id_rd_i, id_branch_i, br_resolved_i,
    input  pc_hold_o, ifid_hold_o, ifid_flush_o, idex_bubble_o, br_err_o
  );

  modport slave (
    input  id_valid_i, id_ra_i, id_rb_i, id_use_a_i, id_use_b_i,
           id_regwrite_i, id_rd_i, id_branch_i, br_resolved_i,
    output pc_hold_o, ifid_hold_o, ifid_flush_o, idex_bubble_o, br_err_o
  );
`endif

endinterface

// File: rtl/hazard_stall_ctrl_scoreboard.sv
// ----------------------------------------------------------------------------
// hazard_scoreboard
// Shift register of in-flight destination registers plus the source compares.
//   clk, reset        : pipeline clock, async active-high reset (clears all)
//   load_v_i/load_rd_i: what enters the ID/EX slot this edge (v=0 is a bubble)
//   use_a_i/ra_i      : operand-A read request
//   use_b_i/rb_i      : operand-B read request
//   match_a_o/b_o     : operand collides with an in-flight producer
// With RF_WRITE_THRU=1 the MEM/WB slot is resolved by the register file's
// write-through, and since nothing ever reads it that slot is not stored.
// Requires SB_DEPTH - RF_WRITE_THRU >= 1.
// ----------------------------------------------------------------------------
module hazard_scoreboard
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int SB_DEPTH      = SB_DEPTH_DEFAULT,
  parameter int RF_WRITE_THRU = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_v_i,
  input  logic [4:0] load_rd_i,
  input  logic       use_a_i,
  input  logic [4:0] ra_i,
  input  logic       use_b_i,
  input  logic [4:0] rb_i,
  output logic       match_a_o,
  output logic       match_b_o
);

  localparam int NCMP = (RF_WRITE_THRU != 0) ? SB_DEPTH - 1 : SB_DEPTH;

  sb_entry_t sb_q [NCMP];
  sb_entry_t sb_d [NCMP];

  always_comb begin
    sb_d[0] = {load_v_i, load_rd_i};
    for (int i = 1; i < NCMP; i++) begin
      sb_d[i] = sb_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCMP; i++) begin
        sb_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCMP; i++) begin
        sb_q[i] <= sb_d[i];
      end
    end
  end

  always_comb begin
    match_a_o = 1'b0;
    match_b_o = 1'b0;
    for (int i = 0; i < NCMP; i++) begin
      match_a_o = match_a_o | src_hit(use_a_i, ra_i, sb_q[i]);
      match_b_o = match_b_o | src_hit(use_b_i, rb_i, sb_q[i]);
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_stall_ctrl
// Interlock controller for the 5-stage LEGv8 pipeline (no forwarding).
// Stalls RAW consumers until their producer leaves the compared window and
// freezes fetch while a branch is being resolved.
//   clk   : pipeline clock
//   reset : asynchronous, active-high
//   bus   : hazard_stall_ctrl_if.slave (decode fields in, pipeline controls out)
// Optional: define HAZARD_PERF_EN to add saturating 32-bit stall_cnt_o
// (hazard cycles in RUN) and brwait_cnt_o (cycles in BR_WAIT).
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_RUN     | normal issue; a hazard stalls PC/IF-ID and bubbles ID/EX
// ST_BR_WAIT | branch issued, fetch frozen and flushed until resolve/timeout
//
// Control outputs are combinational so a stall takes effect in the same
// cycle the dependent instruction sits in ID; br_err is registered.
// ----------------------------------------------------------------------------
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int SB_DEPTH      = SB_DEPTH_DEFAULT,
  parameter int RF_WRITE_THRU = 1,
  parameter int BR_TIMEOUT    = 8
) (
  input logic                clk,
  input logic                reset,
  hazard_stall_ctrl_if.slave bus
);

  localparam int CW = $clog2(BR_TIMEOUT + 1);

  state_e        state_q;
  logic [CW-1:0] br_cnt_q;
  logic          br_err_q;

  logic match_a;
  logic match_b;
  logic hazard;
  logic issue;
  logic in_run;
  logic load_v;
  logic br_timeout;

  assign in_run = (state_q == ST_RUN);
  assign hazard = bus.id_valid_i & (match_a | match_b);
  assign issue  = bus.id_valid_i & ~hazard & in_run;
  assign load_v = issue & bus.id_regwrite_i & (bus.id_rd_i != XZR);

  // Resolution wins over timeout when both land on the last allowed cycle.
  assign br_timeout = ~in_run & ~bus.br_resolved_i &
                      (br_cnt_q == CW'(BR_TIMEOUT - 1));

  hazard_scoreboard #(
    .SB_DEPTH      (SB_DEPTH),
    .RF_WRITE_THRU (RF_WRITE_THRU)
  ) u_sb (
    .clk       (clk),
    .reset     (reset),
    .load_v_i  (load_v),
    .load_rd_i (bus.id_rd_i),
    .use_a_i   (bus.id_use_a_i),
    .ra_i      (bus.id_ra_i),
    .use_b_i   (bus.id_use_b_i),
    .rb_i      (bus.id_rb_i),
    .match_a_o (match_a),
    .match_b_o (match_b)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_RUN;
      br_cnt_q <= '0;
      br_err_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (bus.br_resolved_i) br_err_q <= 1'b1;
          if (issue && bus.id_branch_i) begin
            state_q  <= ST_BR_WAIT;
            br_cnt_q <= '0;
          end
        end
        ST_BR_WAIT: begin
          if (bus.br_resolved_i) begin
            state_q <= ST_RUN;
          end else if (br_timeout) begin
            state_q  <= ST_RUN;
            br_err_q <= 1'b1;
          end else begin
            br_cnt_q <= br_cnt_q + CW'(1);
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  // On the exit cycle of BR_WAIT the PC is released so the branch target
  // (or the fall-through after a timeout) is loaded; the flush still applies.
  assign bus.pc_hold_o     = in_run ? hazard : ~(bus.br_resolved_i | br_timeout);
  assign bus.ifid_hold_o   = in_run & hazard;
  assign bus.ifid_flush_o  = ~in_run;
  assign bus.idex_bubble_o = ~in_run | hazard;
  assign bus.br_err_o      = br_err_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] brwait_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q  <= '0;
      brwait_cnt_q <= '0;
    end else begin
      if (in_run && hazard && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (!in_run && (brwait_cnt_q != '1)) begin
        brwait_cnt_q <= brwait_cnt_q + 32'd1;
      end
    end
  end

  assign bus.stall_cnt_o  = stall_cnt_q;
  assign bus.brwait_cnt_o = brwait_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// ----------------------------------------------------------------------------
// tb_hazard_stall_ctrl
// Table-driven directed vectors, hand sequences for reset/timeout corners,
// then randomized stimulus against a register-age reference model.
// Output vector packing used throughout: {pc_hold, ifid_hold, ifid_flush,
// idex_bubble, br_err}.
// ----------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

  localparam int SB_DEPTH      = 3;
  localparam int RF_WRITE_THRU = 1;
  localparam int BR_TIMEOUT    = 8;
  // A producer issued at cycle t blocks readers up to cycle t + WINDOW.
  localparam int WINDOW        = SB_DEPTH - RF_WRITE_THRU;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  hazard_stall_ctrl_if bus_if ();

  hazard_stall_ctrl #(
    .SB_DEPTH      (SB_DEPTH),
    .RF_WRITE_THRU (RF_WRITE_THRU),
    .BR_TIMEOUT    (BR_TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       v;
    logic [4:0] ra;
    logic [4:0] rb;
    logic       ua;
    logic       ub;
    logic       rw;
    logic [4:0] rd;
    logic       br;
    logic       res;
    logic [4:0] e;
  } vec_t;

  vec_t tbl [22];

  function automatic vec_t mk(logic v, logic [4:0] ra, logic [4:0] rb, logic ua,
                              logic ub, logic rw, logic [4:0] rd, logic br,
                              logic res, logic [4:0] e);
    vec_t t;
    t.v = v; t.ra = ra; t.rb = rb; t.ua = ua; t.ub = ub;
    t.rw = rw; t.rd = rd; t.br = br; t.res = res; t.e = e;
    return t;
  endfunction

  function automatic vec_t idle(logic res, logic [4:0] e);
    return mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, res, e);
  endfunction

  function automatic logic [4:0] outs();
    return {bus_if.pc_hold_o, bus_if.ifid_hold_o, bus_if.ifid_flush_o,
            bus_if.idex_bubble_o, bus_if.br_err_o};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t t);
    bus_if.id_valid_i    = t.v;
    bus_if.id_ra_i       = t.ra;
    bus_if.id_rb_i       = t.rb;
    bus_if.id_use_a_i    = t.ua;
    bus_if.id_use_b_i    = t.ub;
    bus_if.id_regwrite_i = t.rw;
    bus_if.id_rd_i       = t.rd;
    bus_if.id_branch_i   = t.br;
    bus_if.br_resolved_i = t.res;
  endtask

  // Inputs change at the falling edge; outputs are sampled 2 units later.
  task automatic run_vec(input vec_t t, input string name);
    @(negedge clk);
    drive(t);
    #2;
    chk(name, {27'd0, outs()}, {27'd0, t.e});
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(idle(1'b0, 5'b0));
    #2;
    chk("reset_outs", {27'd0, outs()}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Reference model: per-register issue cycle and branch issue cycle.
  int now;
  int last_issue [32];
  bit m_br;
  int br_cyc;
  bit m_err;
  int m_stall;
  int m_brwait;

  function automatic bit blocked(logic [4:0] r);
    return (r != 5'd31) && ((now - last_issue[r]) <= WINDOW);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) last_issue[i] = -1000;
    m_br = 0; m_err = 0; m_stall = 0; m_brwait = 0;
  endtask

  function automatic logic [4:0] rnd_reg();
    int r;
    r = $urandom_range(0, 8);
    return (r == 8) ? 5'd31 : 5'(r);
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected end before t=400000");
    $fatal(1);
  end

  initial begin
    vec_t rv;
    bit   hz, tmo;
    int   waited;
    logic [4:0] exp_o;

    tbl[0]  = mk(1, 5'd2,  5'd3,  1, 1, 1, 5'd1,  0, 0, 5'b00000); // ADD X1
    tbl[1]  = mk(1, 5'd1,  5'd3,  1, 1, 1, 5'd2,  0, 0, 5'b11010); // ADD X2,X1,X3
    tbl[2]  = mk(1, 5'd1,  5'd3,  1, 1, 1, 5'd2,  0, 0, 5'b11010);
    tbl[3]  = mk(1, 5'd1,  5'd3,  1, 1, 1, 5'd2,  0, 0, 5'b00000); // issues
    tbl[4]  = mk(1, 5'd4,  5'd5,  1, 1, 1, 5'd31, 0, 0, 5'b00000); // writes XZR
    tbl[5]  = mk(1, 5'd31, 5'd31, 1, 1, 0, 5'd0,  0, 0, 5'b00000); // reads XZR
    tbl[6]  = mk(1, 5'd7,  5'd8,  1, 1, 0, 5'd6,  0, 0, 5'b00000); // no RegWrite
    tbl[7]  = mk(1, 5'd6,  5'd6,  1, 1, 0, 5'd0,  0, 0, 5'b00000);
    tbl[8]  = mk(1, 5'd0,  5'd9,  0, 1, 0, 5'd0,  1, 0, 5'b00000); // CBZ
    tbl[9]  = idle(0, 5'b10110);
    tbl[10] = idle(0, 5'b10110);
    tbl[11] = idle(1, 5'b00110);                                    // resolve
    tbl[12] = idle(0, 5'b00000);
    tbl[13] = idle(1, 5'b00000);                                    // spurious
    tbl[14] = idle(0, 5'b00001);
    tbl[15] = mk(1, 5'd1,  5'd2,  1, 1, 1, 5'd10, 0, 0, 5'b00001); // writes X10
    tbl[16] = mk(1, 5'd0,  5'd10, 0, 1, 0, 5'd0,  1, 0, 5'b11011); // CBZ X10
    tbl[17] = mk(1, 5'd0,  5'd10, 0, 1, 0, 5'd0,  1, 0, 5'b11011);
    tbl[18] = mk(1, 5'd0,  5'd10, 0, 1, 0, 5'd0,  1, 0, 5'b00001);
    tbl[19] = idle(0, 5'b10111);
    tbl[20] = idle(1, 5'b00111);
    tbl[21] = idle(0, 5'b00001);

    drive(idle(1'b0, 5'b0));
    #3;
    chk("reset_init", {27'd0, outs()}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 22; i++) begin
      run_vec(tbl[i], $sformatf("tbl_row%0d", i));
    end

    // Branch timeout: 8 BR_WAIT cycles, PC released on the 8th, sticky error.
    do_reset();
    run_vec(mk(1, 5'd0, 5'd4, 0, 1, 0, 5'd0, 1, 0, 5'b00000), "to_issue");
    for (int k = 0; k < BR_TIMEOUT - 1; k++) begin
      run_vec(idle(0, 5'b10110), $sformatf("to_wait%0d", k));
    end
    run_vec(idle(0, 5'b00110), "to_exit");
    run_vec(idle(0, 5'b00001), "to_err");
    run_vec(mk(1, 5'd1, 5'd2, 1, 1, 1, 5'd3, 0, 0, 5'b00001), "to_sticky1");
    run_vec(idle(0, 5'b00001), "to_sticky2");
    do_reset();
    run_vec(idle(0, 5'b00000), "err_cleared");

    // Reset in the middle of a stall: the producer is forgotten.
    run_vec(mk(1, 5'd0, 5'd0, 0, 0, 1, 5'd5, 0, 0, 5'b00000), "rs_prod");
    run_vec(mk(1, 5'd5, 5'd6, 1, 1, 1, 5'd7, 0, 0, 5'b11010), "rs_stall");
    #1 reset = 1'b1;
    #1 chk("rs_during", {27'd0, outs()}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #2 chk("rs_after", {27'd0, outs()}, 32'd0);

    // Reset in the middle of BR_WAIT: back to RUN, no flush, no error.
    run_vec(mk(1, 5'd0, 5'd12, 0, 1, 0, 5'd0, 1, 0, 5'b00000), "rb_issue");
    run_vec(idle(0, 5'b10110), "rb_wait");
    #1 reset = 1'b1;
    #1 chk("rb_during", {27'd0, outs()}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(mk(1, 5'd1, 5'd2, 1, 1, 1, 5'd3, 0, 0, 5'b0));
    #2 chk("rb_after", {27'd0, outs()}, 32'd0);
    run_vec(idle(0, 5'b00000), "rb_run");

`ifdef HAZARD_PERF_EN
    do_reset();
    run_vec(mk(1, 5'd2, 5'd3, 1, 1, 1, 5'd1, 0, 0, 5'b00000), "pf_prod");
    run_vec(mk(1, 5'd1, 5'd3, 1, 1, 1, 5'd2, 0, 0, 5'b11010), "pf_stall1");
    run_vec(mk(1, 5'd1, 5'd3, 1, 1, 1, 5'd2, 0, 0, 5'b11010), "pf_stall2");
    run_vec(mk(1, 5'd1, 5'd3, 1, 1, 1, 5'd2, 0, 0, 5'b00000), "pf_issue");
    run_vec(mk(1, 5'd0, 5'd9, 0, 1, 0, 5'd0, 1, 0, 5'b00000), "pf_cbz");
    run_vec(idle(0, 5'b10110), "pf_wait1");
    run_vec(idle(0, 5'b10110), "pf_wait2");
    run_vec(idle(1, 5'b00110), "pf_resolve");
    run_vec(idle(0, 5'b00000), "pf_run");
    chk("pf_stall_cnt", bus_if.stall_cnt_o, 32'd2);
    chk("pf_brwait_cnt", bus_if.brwait_cnt_o, 32'd3);
`endif

    // Randomized phase against the reference model.
    do_reset();
    model_reset();
    now = 0;
    for (int n = 0; n < 3000; n++) begin
      now++;
      @(negedge clk);
      reset = 1'b0;
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b1;
        drive(idle(1'b0, 5'b0));
        #2 chk("rand_reset", {27'd0, outs()}, 32'd0);
        model_reset();
        continue;
      end
      rv.v   = ($urandom_range(0, 3) != 0);
      rv.ra  = rnd_reg();
      rv.rb  = rnd_reg();
      rv.ua  = 1'($urandom_range(0, 1));
      rv.ub  = 1'($urandom_range(0, 1));
      rv.rw  = ($urandom_range(0, 2) != 0);
      rv.rd  = rnd_reg();
      rv.br  = ($urandom_range(0, 9) == 0);
      rv.res = m_br ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 60) == 0);
      rv.e   = 5'b0;
      drive(rv);
      #2;
      hz  = rv.v && ((rv.ua && blocked(rv.ra)) || (rv.ub && blocked(rv.rb)));
      tmo = 1'b0;
      if (!m_br) begin
        exp_o = {hz, hz, 1'b0, hz, m_err};
      end else begin
        waited = now - br_cyc - 1;
        tmo    = !rv.res && (waited == BR_TIMEOUT - 1);
        exp_o  = {!(rv.res || tmo), 1'b0, 1'b1, 1'b1, m_err};
      end
      chk($sformatf("rand_cyc%0d", n), {27'd0, outs()}, {27'd0, exp_o});
      if (!m_br) begin
        if (hz) m_stall++;
        if (rv.res) m_err = 1;
        if (rv.v && !hz) begin
          if (rv.rw && rv.rd != 5'd31) last_issue[rv.rd] = now;
          if (rv.br) begin
            m_br   = 1;
            br_cyc = now;
          end
        end
      end else begin
        m_brwait++;
        if (rv.res || tmo) begin
          m_br = 0;
          if (tmo) m_err = 1;
        end
      end
    end
`ifdef HAZARD_PERF_EN
    @(negedge clk);
    reset = 1'b0;
    drive(idle(1'b0, 5'b0));
    #1;
    chk("rand_stall_cnt", bus_if.stall_cnt_o, m_stall);
    chk("rand_brwait_cnt", bus_if.brwait_cnt_o, m_brwait);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
